// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multiply/divide sequencer.
// The sequencer and its iteration core both import this package.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITERS = DEF_WIDTH;
  localparam int CNT_W     = $clog2(DEF_ITERS);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One combinational step: a shift-add multiply step or a restoring divide step.
// Multiply keeps {acc_hi[W-1:0], acc_lo} as the product; divide keeps remainder/quotient.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum     = acc_hi + {1'b0, opnd & {WIDTH{acc_lo[0]}}};
    shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    if (is_div) begin
      // borrow out of the trial subtraction means restore the shifted value
      acc_hi_nxt = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      acc_hi_nxt = {1'b0, sum[WIDTH:1]};
      acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Operates on magnitudes, applying sign correction in a dedicated FIX cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_BITS = $clog2(ITERS);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(ITERS - 1);

  state_t               state;
  logic [1:0]           op_r;
  logic                 sa, sb;
  logic [CNT_BITS-1:0]  cnt;
  logic [WIDTH:0]       acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [WIDTH-1:0]     opnd;

  logic [WIDTH:0]       acc_hi_nxt;
  logic [WIDTH-1:0]     acc_lo_nxt;
  logic                 in_div, in_sgn;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div     (op_is_div(op_r)),
    .acc_hi     (acc_hi),
    .acc_lo     (acc_lo),
    .opnd       (opnd),
    .acc_hi_nxt (acc_hi_nxt),
    .acc_lo_nxt (acc_lo_nxt)
  );

  always_comb begin
    in_div = op_is_div(op);
    in_sgn = op_is_signed(op);
    abs_a  = (in_sgn && A[WIDTH-1]) ? -A : A;
    abs_b  = (in_sgn && B[WIDTH-1]) ? -B : B;
    prod   = {acc_hi[WIDTH-1:0], acc_lo};
    // sa/sb are only ever set for signed ops, so no op check is needed here
    if (op_is_div(op_r)) begin
      fix_lo = (sa ^ sb) ? -acc_lo : acc_lo;
      fix_hi = sa ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    end else begin
      if (sa ^ sb) prod = -prod;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_r        <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy        <= 1'b0;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start && !flush) begin
            op_r   <= op;
            sa     <= in_sgn & A[WIDTH-1];
            sb     <= in_sgn & B[WIDTH-1];
            cnt    <= '0;
            acc_hi <= '0;
            busy   <= 1'b1;
            if (in_div && (B == '0)) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              state  <= CALC;
              acc_lo <= in_div ? abs_a : abs_b;
              opnd   <= in_div ? abs_b : abs_a;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= acc_hi_nxt;
            acc_lo <= acc_lo_nxt;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized + directed bench for muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  muldiv_sequencer #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS-style HI/LO semantics computed with 64-bit integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output bit dz);
    longint sa_, sb_, q, r;
    logic [63:0] p;
    sa_ = $signed(a);
    sb_ = $signed(b);
    dz  = 1'b0;
    case (o)
      2'd0: begin p = sa_ * sb_; h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
      2'd2: begin
        if (b == 0) dz = 1'b1;
        else begin q = sa_ / sb_; r = sa_ % sb_; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (b == 0) dz = 1'b1;
        else begin l = a / b; h = a % b; end
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit with_mthi, input logic [31:0] wd);
    bit dz;
    int cyc;
    if (with_mthi) m_hi = wd;
    model(o, a, b, m_hi, m_lo, dz);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; mthi = with_mthi; wdata = wd;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (!busy) chk({tag, " busy"}, busy, 1);
      @(negedge clk);
      cyc++;
    end
    chk({tag, " lat"}, cyc, dz ? 1 : 34);
    chk({tag, " busy@done"}, busy, 1);
    chk({tag, " dz"}, div_by_zero, dz);
    chk({tag, " hi"}, hi, m_hi);
    chk({tag, " lo"}, lo, m_lo);
    @(negedge clk);
    chk({tag, " idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    bit saw_done;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    #1;
    chk("rst", {hi, lo, busy, done, div_by_zero}, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 0, 0);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("divu", 2'd3, 32'd100, 32'd7, 0, 0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    // MTHI then MTLO, then divide by zero must leave them intact
    @(negedge clk); mthi = 1'b1; wdata = 32'h11;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h22;
    @(negedge clk); mtlo = 1'b0;
    m_hi = 32'h11; m_lo = 32'h22;
    chk("mthi", hi, 32'h11);
    chk("mtlo", lo, 32'h22);
    run_op("divu_dz", 2'd3, 32'd5, 32'd0, 0, 0);

    // flush mid-CALC, with an ignored start while busy
    @(negedge clk); start = 1'b1; op = 2'd1; A = 32'd7; B = 32'd9;
    @(negedge clk); start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin start = 1'b1; op = 2'd3; A = 32'd1; B = 32'd1; end
      if (c == 6) start = 1'b0;
      if (c == 10) flush = 1'b1;
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    chk("flush busy", busy, 0);
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("flush nodone", saw_done, 0);
    chk("flush hi", hi, m_hi);
    chk("flush lo", lo, m_lo);

    run_op("multu_fresh", 2'd1, 32'd7, 32'd9, 0, 0);

    // flush beats start in IDLE
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'd0; A = 32'd3; B = 32'd3;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("idle flush busy", busy, 0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("idle flush nodone", saw_done, 0);

    run_op("mthi+start", 2'd0, 32'hFFFF_0000, 32'h0001_2345, 1, 32'hDEAD_BEEF);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      run_op($sformatf("rnd%0d", i), ro, ra, rb, $urandom_range(0, 7) == 0, $urandom);
    end

    // async reset 20 cycles into a DIV
    @(negedge clk); start = 1'b1; op = 2'd2; A = 32'h1234_5678; B = 32'd3;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst outs", {hi, lo, busy, done, div_by_zero}, '0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("midrst nodone", saw_done, 0);
    chk("midrst hilo", {hi, lo}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers. It sequences iterative MULT/MULTU/DIV/DIVU operations off the single-cycle ALU path. It holds the pipeline with a busy stall while an operation runs, and serves MFHI/MFLO/MTHI/MTLO. It sits beside the ALU in EX and is driven by the main control decoder.

Parameters:
WIDTH, 32, operand and HI/LO width
ITERS, WIDTH, iterations per operation (one bit per cycle); must equal WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request to launch an operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  in  WIDTH  operand rs (multiplicand or dividend)
B  in  WIDTH  operand rt (multiplier or divisor)
flush  in  1  pipeline flush; abandons an in-flight operation
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data
hi  out  WIDTH  HI register (remainder / product upper half)
lo  out  WIDTH  LO register (quotient / product lower half)
busy  out  1  operation in progress; stalls MFHI/MFLO/mult/div issue
done  out  1  one-cycle pulse when HI/LO have been updated
div_by_zero  out  1  valid with done; set when DIV/DIVU had B == 0

Behaviour:
- Reset (rst_n low, async): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, all internal registers 0. Reset mid-operation discards the operation with no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0: latch op, |A| and |B| (abs only for signed ops), and the sign bits. Clear the iteration counter and go to CALC.
  - DIV/DIVU with B==0: go directly to DONE and set the dz flag.
- CALC: one iteration per cycle via the iteration core. Counter runs 0..ITERS-1; after iteration ITERS-1, go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on remainder/quotient.
- FIX: sign correction for signed ops.
  - Product is negated when sA^sB.
  - Quotient is negated when sA^sB; remainder takes the sign of A.
  - Write hi/lo. Go to DONE.
- DONE: done=1 for exactly this cycle; div_by_zero=dz. Next state IDLE.
- Divide by zero: hi/lo unchanged.
- Latency: start accepted at edge T0 gives done high in cycle T0+ITERS+2 (34 for WIDTH=32); hi/lo are valid from that cycle. Divide by zero gives done in cycle T0+1.
- busy=1 in CALC, FIX, DONE; 0 in IDLE. busy goes high the cycle after start is accepted.
- start while busy: ignored; no queuing.
- flush:
  - In CALC/FIX: next state IDLE, hi/lo unchanged, no done.
  - In IDLE with start: flush wins, nothing launched.
  - In DONE: has no effect; the result already committed.
- mthi/mtlo: honoured only in IDLE, taking effect at the next edge. Ignored while busy.
- mthi/mtlo and start in the same IDLE cycle: the move is written, and the operation launches normally and later overwrites hi/lo.
- Arithmetic:
  - Signed DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (natural magnitude wrap); no flag.
  - The multiply accumulator is 2*WIDTH bits. The divide remainder register is WIDTH+1 bits to hold the subtraction borrow.
- done, div_by_zero and busy are registered outputs.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - state enum (IDLE, CALC, FIX, DONE)
  - counter width constant CNT_W = clog2(ITERS)
- Sub-module muldiv_iter_core: combinational single-step datapath. Inputs are the accumulator/remainder, quotient and operand; outputs are the next values for one shift-add or one shift-subtract step, selected by an is_div input.
- The sequencer owns all registers, the FSM and the sign fix.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high cycles 1..34.
- MULTU A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=100, B=7 -> lo=0x0000000E, hi=0x00000002.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=5, B=0 after MTHI 0x11 / MTLO 0x22 -> done at cycle 1 with div_by_zero=1; hi=0x11, lo=0x22 unchanged.
- MULTU 7*9 launched, flush at cycle 10, second start during CALC ignored -> no done, busy low at cycle 11, hi/lo unchanged.
- Fresh MULTU 7*9 -> lo=63.
- rst_n pulsed low at cycle 20 of a DIV -> all outputs 0 immediately; no done afterwards.
